led_sched: RTL and testbench

LED_SCHED -- requirements
Module: led_sched

---
 rtl/led_sched.sv | 115 +++++++++++
 tb/tb_led_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_sched.sv
// LED bank scheduler: four requesters share an 8-bit LED bank under rotating priority with a minimum dwell.
// Optional build macro LED_HEARTBEAT_EN drives a heartbeat bit on o_led[7] while no requester owns the bank.
module led_sched #(
   parameter int DWELL  = 4,
   parameter int HB_BIT = 23
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [3:0]  i_req,
   input  logic [31:0] i_pat,
   output logic [3:0]  o_gnt,
   output logic [7:0]  o_led,
   output logic        o_busy
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [15:0] DWELL_C = 16'(DWELL);

   if (DWELL < 1 || DWELL > 65535 || HB_BIT < 0 || HB_BIT > 31) begin : g_param_check
      $error("led_sched: DWELL or HB_BIT out of range");
   end

   state_t      state, state_d;
   logic [1:0]  last_owner, last_d;
   logic [15:0] cnt, cnt_d;
   logic [3:0]  gnt_d;
   logic [7:0]  led_d;
   logic [7:0]  idle_led;
   logic [1:0]  pick;
   logic        pick_vld;
   logic [3:0]  owner_mask;
   logic        others;

`ifdef LED_HEARTBEAT_EN
   logic [31:0] hb_ctr;

   always_ff @(posedge i_clk) begin
      if (i_rst) hb_ctr <= '0;
      else       hb_ctr <= hb_ctr + 32'd1;
   end

   assign idle_led = {hb_ctr[HB_BIT], 7'b0};
`else
   assign idle_led = 8'h00;
`endif

   // Rotating priority: scan upward from the requester after the last owner;
   // the last owner itself is considered last.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!pick_vld && i_req[last_owner + 2'(i)]) begin
            pick     = last_owner + 2'(i);
            pick_vld = 1'b1;
         end
      end
   end

   // While in OWN, last_owner is the current owner.
   assign owner_mask = 4'b0001 << last_owner;
   assign others     = |(i_req & ~owner_mask);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state;
      last_d  = last_owner;
      cnt_d   = cnt;
      gnt_d   = '0;
      led_d   = idle_led;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_d = OWN;
               last_d  = pick;
               cnt_d   = 16'd1;
               gnt_d   = 4'b0001 << pick;
            end
         end
         OWN: begin
            led_d = i_pat[{last_owner, 3'b000} +: 8];
            if (!i_req[last_owner]) begin
               state_d = IDLE;
            end else if (cnt >= DWELL_C && others) begin
               state_d = IDLE;
            end else begin
               gnt_d = owner_mask;
               if (cnt < DWELL_C) cnt_d = cnt + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         last_owner <= 2'd3;
         cnt        <= '0;
         o_gnt      <= '0;
         o_led      <= '0;
      end else begin
         state      <= state_d;
         last_owner <= last_d;
         cnt        <= cnt_d;
         o_gnt      <= gnt_d;
         o_led      <= led_d;
      end
   end

   assign o_busy = |o_gnt;

endmodule

// File: tb/tb_led_sched.sv
// Scoreboard bench for led_sched: stimulus pushes per-edge expectations, a monitor pops and compares.
// Idle LED expectations follow the heartbeat model when LED_HEARTBEAT_EN is defined (HB_BIT=3).
module tb_led_sched;

   localparam logic [31:0] PAT  = 32'hC35A3CA5;
   localparam logic [31:0] PAT2 = 32'hC35A7EA5;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] led;
      string      name;
   } exp_t;

   logic        clk;
   logic        i_rst;
   logic [3:0]  i_req;
   logic [31:0] i_pat;
   logic [3:0]  o_gnt;
   logic [7:0]  o_led;
   logic        o_busy;

   exp_t        sb[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_step = 0;
   logic [31:0] pat_v = PAT;
`ifdef LED_HEARTBEAT_EN
   logic [31:0] hb_ctr = '0;
`endif

   led_sched #(.DWELL(4), .HB_BIT(3)) dut (
      .i_clk  (clk),
      .i_rst  (i_rst),
      .i_req  (i_req),
      .i_pat  (i_pat),
      .o_gnt  (o_gnt),
      .o_led  (o_led),
      .o_busy (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] slice(input int k);
      return pat_v[8*k +: 8];
   endfunction

   // Drive one cycle of inputs and record what the DUT must show after the next edge.
   task automatic step(input logic rst, input logic [3:0] req, input logic [31:0] pat,
                       input logic [3:0] gnt, input logic [7:0] led, input bit use_idle,
                       input string tag);
      exp_t       e;
      logic [7:0] idle;
      @(negedge clk);
      i_rst = rst;
      i_req = req;
      i_pat = pat;
      idle  = 8'h00;
`ifdef LED_HEARTBEAT_EN
      idle   = {hb_ctr[3], 7'b0};
      hb_ctr = rst ? 32'd0 : hb_ctr + 32'd1;
`endif
      e.gnt  = gnt;
      e.led  = use_idle ? idle : led;
      e.name = $sformatf("%s#%0d", tag, n_step);
      n_step++;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.name, ".gnt"},  {4'b0, o_gnt},  {4'b0, e.gnt});
         check({e.name, ".led"},  o_led,          e.led);
         check({e.name, ".busy"}, {7'b0, o_busy}, {7'b0, |e.gnt});
      end
   end

   initial begin
      i_rst = 1'b1;
      i_req = '0;
      i_pat = PAT;

      step(1, 4'b0000, PAT, 4'b0000, 8'h00, 0, "rst");
      step(1, 4'b0000, PAT, 4'b0000, 8'h00, 0, "rst");

      // Single requester 0: grant after one edge, pattern one edge later.
      step(0, 4'b0001, PAT, 4'b0001, 8'h00, 1, "first_grant");
      step(0, 4'b0001, PAT, 4'b0001, 8'hA5, 0, "led_a5");
      step(0, 4'b0001, PAT, 4'b0001, 8'hA5, 0, "hold_a5");
      step(0, 4'b0000, PAT, 4'b0000, 8'hA5, 0, "drop_req");
      step(0, 4'b0000, PAT, 4'b0000, 8'h00, 1, "idle");

      // Full contention: 0,1,2,3,0 with four grant cycles and one idle cycle each.
      step(1, 4'b0000, PAT, 4'b0000, 8'h00, 0, "rst2");
      for (int k = 0; k < 5; k++) begin
         int         o;
         logic [3:0] g;
         o = k % 4;
         g = 4'b0001 << o;
         step(0, 4'b1111, PAT, g, 8'h00, 1, "rot_grant");
         for (int j = 0; j < 3; j++) step(0, 4'b1111, PAT, g, slice(o), 0, "rot_hold");
         step(0, 4'b1111, PAT, 4'b0000, slice(o), 0, "rot_release");
      end
      step(0, 4'b0000, PAT, 4'b0000, 8'h00, 1, "idle");

      // Owner 2 drops its request early; next grant rotates to 3.
      step(0, 4'b0100, PAT, 4'b0100, 8'h00, 1, "g2");
      step(0, 4'b0100, PAT, 4'b0100, 8'h5A, 0, "g2_hold");
      step(0, 4'b1011, PAT, 4'b0000, 8'h5A, 0, "g2_early_rel");
      step(0, 4'b1011, PAT, 4'b1000, 8'h00, 1, "g3_rotate");
      step(0, 4'b1011, PAT, 4'b1000, 8'hC3, 0, "g3_hold");

      // Reset mid-grant, then lowest index wins.
      step(1, 4'b1011, PAT, 4'b0000, 8'h00, 0, "rst_mid");
      step(0, 4'b1011, PAT, 4'b0001, 8'h00, 1, "post_rst_g0");
      step(0, 4'b0000, PAT, 4'b0000, 8'hA5, 0, "g0_drop");
      step(0, 4'b0000, PAT, 4'b0000, 8'h00, 1, "idle");

      // Lone requester 1 held for 100 cycles; pattern change tracked each cycle.
      step(0, 4'b0010, PAT, 4'b0010, 8'h00, 1, "g1");
      for (int i = 1; i < 100; i++)
         step(0, 4'b0010, (i >= 50) ? PAT2 : PAT, 4'b0010,
              (i >= 50) ? 8'h7E : 8'h3C, 0, "g1_hold");
      step(0, 4'b1011, PAT2, 4'b0000, 8'h7E, 0, "g1_sat_rel");
      step(0, 4'b1011, PAT, 4'b1000, 8'h00, 1, "g3");

      // Non-owner request changes inside the dwell window are ignored.
      step(0, 4'b1001, PAT, 4'b1000, 8'hC3, 0, "g3_ignore");
      step(0, 4'b1101, PAT, 4'b1000, 8'hC3, 0, "g3_ignore");
      step(0, 4'b1000, PAT, 4'b1000, 8'hC3, 0, "g3_alone");
      step(0, 4'b1000, PAT, 4'b1000, 8'hC3, 0, "g3_alone");
      step(0, 4'b1100, PAT, 4'b0000, 8'hC3, 0, "g3_rel");
      step(0, 4'b0100, PAT, 4'b0100, 8'h00, 1, "g2_after");
      step(0, 4'b0000, PAT, 4'b0000, 8'h5A, 0, "g2_drop");

      // Idle stretch: constant zero, or heartbeat on bit 7.
      for (int i = 0; i < 20; i++) step(0, 4'b0000, PAT, 4'b0000, 8'h00, 1, "idle_hb");

      for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
